// File: rtl/ins_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Single outstanding imem request; EX redirects squash in-flight fetches.
module ins_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_stall_in,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_ins_out,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_pc_plus_4_out,
    output logic        if_valid_out
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] hold_data;
    logic        drop;

    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_REQ;
            pc               <= RESET_PC;
            req_pc           <= RESET_PC;
            hold_data        <= NOP_INSTR;
            drop             <= 1'b0;
            if_ins_out       <= NOP_INSTR;
            if_pc_out        <= 32'h0;
            if_pc_plus_4_out <= 32'h0;
            if_valid_out     <= 1'b0;
        end else if (redirect_valid_in) begin
            if_ins_out   <= NOP_INSTR;
            if_valid_out <= 1'b0;
            pc           <= {redirect_pc_in[31:2], 2'b00};
            unique case (state)
                S_REQ: begin
                    // accepted request still returns data; mark it stale
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                        drop  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                S_HOLD:  state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end else begin
            if (!pipeline_stall_in) begin
                if_ins_out   <= NOP_INSTR;
                if_valid_out <= 1'b0;
            end
            unique case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else if (!pipeline_stall_in) begin
                            if_ins_out       <= imem_resp_data;
                            if_pc_out        <= req_pc;
                            if_pc_plus_4_out <= req_pc + 32'd4;
                            if_valid_out     <= 1'b1;
                            state            <= S_REQ;
                        end else begin
                            hold_data <= imem_resp_data;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!pipeline_stall_in) begin
                        if_ins_out       <= hold_data;
                        if_pc_out        <= req_pc;
                        if_pc_plus_4_out <= req_pc + 32'd4;
                        if_valid_out     <= 1'b1;
                        state            <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed scenarios plus randomized traffic
// checked against a transaction-level fetch model.
module tb_ins_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] WRAP = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, redir;
    logic [31:0] redir_pc;
    logic        req_valid, req_ready, resp_valid, vld;
    logic [31:0] req_addr, resp_data, ins, pc_o, pc4_o;

    logic        w_rst, w_req_valid, w_ready, w_resp_valid, w_vld;
    logic [31:0] w_req_addr, w_resp_data, w_ins, w_pc, w_pc4;

    ins_fetch dut (
        .clk(clk), .rst(rst),
        .pipeline_stall_in(stall),
        .redirect_valid_in(redir),
        .redirect_pc_in(redir_pc),
        .imem_req_valid(req_valid),
        .imem_req_addr(req_addr),
        .imem_req_ready(req_ready),
        .imem_resp_valid(resp_valid),
        .imem_resp_data(resp_data),
        .if_ins_out(ins),
        .if_pc_out(pc_o),
        .if_pc_plus_4_out(pc4_o),
        .if_valid_out(vld)
    );

    ins_fetch #(.RESET_PC(WRAP)) u_wrap (
        .clk(clk), .rst(w_rst),
        .pipeline_stall_in(1'b0),
        .redirect_valid_in(1'b0),
        .redirect_pc_in(32'h0),
        .imem_req_valid(w_req_valid),
        .imem_req_addr(w_req_addr),
        .imem_req_ready(w_ready),
        .imem_resp_valid(w_resp_valid),
        .imem_resp_data(w_resp_data),
        .if_ins_out(w_ins),
        .if_pc_out(w_pc),
        .if_pc_plus_4_out(w_pc4),
        .if_valid_out(w_vld)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    // memory model
    bit          busy = 0;
    logic [31:0] maddr = 0;
    int          mdelay = 0;
    int          force_delay = 0;
    bit          rdy_rand = 0;
    bit          rdy_val = 1;
    bit          w_busy = 0;
    logic [31:0] w_maddr = 0;

    // fetch reference model
    typedef struct {
        logic [31:0] a;
        int          e;
    } pend_t;
    pend_t       pend[$];
    logic [31:0] dq[$];
    logic [31:0] exp_pc = 0;
    int          epoch = 0;
    logic [31:0] pv_ins = 0, pv_pc = 0, pv_pc4 = 0;
    logic        pv_vld = 0;

    task automatic step();
        logic        p_rst, p_stall, p_redir, p_hs, p_resp, p_valid;
        logic [31:0] p_rpc, p_addr, a;
        logic        w_hs;
        logic [31:0] w_hs_addr;
        pend_t       t;

        resp_valid = busy && (mdelay == 0) && !rst;
        resp_data  = resp_valid ? word_at(maddr) : $urandom;
        req_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        w_ready      = 1'b1;
        w_resp_valid = w_busy;
        w_resp_data  = word_at(w_maddr);
        #1;
        p_rst   = rst;
        p_stall = stall;
        p_redir = redir;
        p_rpc   = redir_pc;
        p_valid = req_valid;
        p_hs    = req_valid && req_ready;
        p_addr  = req_addr;
        p_resp  = resp_valid;
        w_hs      = w_req_valid;
        w_hs_addr = w_req_addr;
        @(posedge clk);
        #1;

        if (p_rst) begin
            chk("rst_req_valid", p_valid, 0);
            exp_pc = 32'h0;
            pend.delete();
            dq.delete();
            epoch++;
            chk("rst_ins", ins, NOP);
            chk("rst_pc", pc_o, 0);
            chk("rst_pc4", pc4_o, 0);
            chk("rst_valid", vld, 0);
        end else begin
            if (p_resp) begin
                if (pend.size() == 0) begin
                    chk("spurious_resp", 1, 0);
                end else begin
                    t = pend.pop_front();
                    if (t.e == epoch && !p_redir) dq.push_back(t.a);
                end
            end
            if (p_hs) begin
                chk("req_addr", p_addr, exp_pc);
                pend.push_back('{p_addr, epoch});
                exp_pc = exp_pc + 32'd4;
            end
            if (p_redir) begin
                exp_pc = {p_rpc[31:2], 2'b00};
                epoch++;
                dq.delete();
                chk("redir_valid", vld, 0);
                chk("redir_ins", ins, NOP);
                chk("redir_pc_kept", pc_o, pv_pc);
            end else if (p_stall) begin
                chk("stall_ins", ins, pv_ins);
                chk("stall_pc", pc_o, pv_pc);
                chk("stall_pc4", pc4_o, pv_pc4);
                chk("stall_valid", vld, pv_vld);
            end else if (vld) begin
                if (dq.size() != 1) begin
                    chk("deliver_count", 32'(dq.size()), 1);
                    dq.delete();
                end else begin
                    a = dq.pop_front();
                    chk("load_ins", ins, word_at(a));
                    chk("load_pc", pc_o, a);
                    chk("load_pc4", pc4_o, a + 32'd4);
                end
            end else begin
                chk("lost_instr", 32'(dq.size()), 0);
                dq.delete();
                chk("bubble_ins", ins, NOP);
                chk("bubble_pc", pc_o, pv_pc);
            end
        end
        if (pend.size() != 0 || dq.size() != 0 || rst)
            chk("no_req_when_busy", req_valid, 0);
        pv_ins = ins;
        pv_pc  = pc_o;
        pv_pc4 = pc4_o;
        pv_vld = vld;

        if (p_rst) begin
            busy = 0;
        end else begin
            if (p_resp) busy = 0;
            else if (busy) mdelay--;
            if (p_hs) begin
                busy   = 1;
                maddr  = p_addr;
                mdelay = (force_delay >= 0) ? force_delay
                                            : int'($urandom_range(0, 2));
            end
        end
        if (w_rst) begin
            w_busy = 0;
        end else begin
            w_busy  = w_hs;
            w_maddr = w_hs_addr;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; stall = 0; redir = 0; redir_pc = 0;
        w_rst = 1;
        req_ready = 0; resp_valid = 0; resp_data = 0;
        w_ready = 1; w_resp_valid = 0; w_resp_data = 0;

        // 1: reset and first fetch
        step();
        step();
        rst = 0;
        step();
        step();
        chk("t1_ins", ins, 32'h0050_0093);
        chk("t1_pc", pc_o, 0);
        chk("t1_pc4", pc4_o, 4);
        chk("t1_valid", vld, 1);
        chk("t1_next_valid", req_valid, 1);
        chk("t1_next_addr", req_addr, 4);

        // 2: stall while response in flight
        step();
        stall = 1;
        step();
        chk("t2_hold_valid", vld, 0);
        chk("t2_hold_req", req_valid, 0);
        step();
        step();
        chk("t2_hold_req2", req_valid, 0);
        stall = 0;
        step();
        chk("t2_ins", ins, word_at(4));
        chk("t2_pc", pc_o, 4);
        chk("t2_valid", vld, 1);

        // 3: redirect while waiting on a slow response
        force_delay = 2;
        step();
        redir = 1; redir_pc = 32'h0000_0103;
        step();
        redir = 0;
        chk("t3_bubble_ins", ins, NOP);
        chk("t3_bubble_valid", vld, 0);
        for (int i = 0; i < 8 && !req_valid; i++) step();
        chk("t3_req_valid", req_valid, 1);
        chk("t3_req_addr", req_addr, 32'h0000_0100);
        force_delay = 0;
        step();
        step();
        chk("t3_pc", pc_o, 32'h0000_0100);
        chk("t3_pc4", pc4_o, 32'h0000_0104);
        chk("t3_valid", vld, 1);

        // 4: redirect and stall together
        stall = 1; redir = 1; redir_pc = 32'h0000_0200;
        step();
        stall = 0; redir = 0;
        chk("t4_flush_valid", vld, 0);
        chk("t4_flush_ins", ins, NOP);
        for (int i = 0; i < 8 && !req_valid; i++) step();
        chk("t4_req_addr", req_addr, 32'h0000_0200);

        // 5: memory not ready
        rdy_val = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_req_valid", req_valid, 1);
            chk("t5_req_addr", req_addr, 32'h0000_0200);
            chk("t5_bubble", vld, 0);
        end
        rdy_val = 1;

        // randomized traffic
        rdy_rand = 1;
        force_delay = -1;
        for (int i = 0; i < 800; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            redir = ($urandom_range(0, 11) == 0);
            redir_pc = ($urandom_range(0, 3) == 0)
                     ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                     : $urandom;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 0; stall = 0; redir = 0; rdy_rand = 0;
        for (int i = 0; i < 6; i++) step();

        // 6: PC wrap and reset while waiting
        w_rst = 0;
        step();
        step();
        chk("t6_pc", w_pc, WRAP);
        chk("t6_pc4_wrap", w_pc4, 0);
        chk("t6_ins", w_ins, word_at(WRAP));
        chk("t6_req_valid", w_req_valid, 1);
        chk("t6_req_addr", w_req_addr, 0);
        step();
        chk("t6_wait_req", w_req_valid, 0);
        w_rst = 1;
        step();
        w_rst = 0;
        #1;
        chk("t6_rst_req_valid", w_req_valid, 1);
        chk("t6_rst_req_addr", w_req_addr, WRAP);
        chk("t6_rst_valid", w_vld, 0);
        chk("t6_rst_ins", w_ins, NOP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
